// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the program counter, issues synchronous imem reads
// and hands words to decode through an output register backed by a 1-entry skid.
module fetch_pc_unit #(
    parameter int                ADDR_W   = 11,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 11'h000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               halt,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pending_pc;
    logic               pending;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic               issue;
    logic               consume;
    logic               out_free;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    // Only one word may be in flight, so issuing stops whenever the response
    // would have nowhere to land (skid occupied or output stalled).
    always_comb begin
        issue = (state == FETCH) & ~halt & ~branch_en & ~skid_valid
                & ~(if_valid & ~id_ready);
        imem_rd_en = issue;
        imem_addr  = pc;
    end

    assign consume  = if_valid & id_ready;
    assign out_free = ~if_valid | id_ready;

    // A branch flushes everything, including the response arriving this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else if (branch_en) begin
            pc         <= branch_addr;
            pending    <= 1'b0;
            skid_valid <= 1'b0;
            if_valid   <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                pc         <= pc + 1'b1;
                pending_pc <= pc;
            end
            if (skid_valid && consume) begin
                if_instr   <= skid_instr;
                if_pc      <= skid_pc;
                skid_valid <= 1'b0;
            end else if (pending && out_free) begin
                if_instr <= imem_rdata;
                if_pc    <= pending_pc;
                if_valid <= 1'b1;
            end else if (pending) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pending_pc;
                skid_valid <= 1'b1;
            end else if (consume) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: queue-based transaction model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        branch_en;
    logic [10:0] branch_addr;
    logic        halt;
    logic        imem_rd_en;
    logic [10:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [10:0] if_pc;
    logic        id_ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    fetch_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .halt        (halt),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [10:0] a);
        return {5'b11000, a ^ 11'h155};
    endfunction

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem_word(imem_addr);
    end

    // Model: words owned by the stage live in a queue (front = what decode sees),
    // plus at most one in-flight read.
    int unsigned m_age      = 0;
    bit          m_halted   = 1'b0;
    logic [10:0] m_pc       = 11'h000;
    logic [10:0] m_q[$];
    bit          m_inflight = 1'b0;
    logic [10:0] m_inflight_pc = 11'h000;

    function automatic bit model_issue();
        return (m_age >= 1) && !m_halted && !halt && !branch_en
               && (m_q.size() == 0 || (m_q.size() == 1 && id_ready));
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_age = 0;
                m_halted = 1'b0;
                m_pc = 11'h000;
                m_q.delete();
                m_inflight = 1'b0;
            end else begin
                bit iss;
                bit fetching;
                iss = model_issue();
                fetching = (m_age >= 1) && !m_halted;
                if (branch_en) begin
                    m_q.delete();
                    m_inflight = 1'b0;
                    m_pc = branch_addr;
                end else begin
                    if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
                    if (m_inflight) m_q.push_back(m_inflight_pc);
                    m_inflight = iss;
                    if (iss) begin
                        m_inflight_pc = m_pc;
                        m_pc = m_pc + 11'd1;
                    end
                end
                if (fetching && halt) m_halted = 1'b1;
                if (m_age < 2) m_age++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checkOutput("cyc_rd_en", 32'(imem_rd_en), 32'(model_issue()));
            checkOutput("cyc_imem_addr", 32'(imem_addr), 32'(m_pc));
            checkOutput("cyc_if_valid", 32'(if_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                checkOutput("cyc_if_pc", 32'(if_pc), 32'(m_q[0]));
                checkOutput("cyc_if_instr", 32'(if_instr), 32'(mem_word(m_q[0])));
            end
        end
    end

    task automatic applyStimulus(input logic be, input logic [10:0] ba, input logic h,
                                 input logic r, input int cycles);
        branch_en   = be;
        branch_addr = ba;
        halt        = h;
        id_ready    = r;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b0;
        branch_en = 1'b0;
        branch_addr = 11'h000;
        halt = 1'b0;
        id_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_if_valid", 32'(if_valid), 0);
        checkOutput("rst_if_pc", 32'(if_pc), 0);
        checkOutput("rst_if_instr", 32'(if_instr), 0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 0);
        checkOutput("rst_rd_en", 32'(imem_rd_en), 0);
        reset = 1'b1;

        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 2);
        checkOutput("lat_not_yet", 32'(if_valid), 0);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 1);
        checkOutput("lat_first_valid", 32'(if_valid), 1);
        checkOutput("lat_first_pc", 32'(if_pc), 0);
        checkOutput("lat_first_instr", 32'(if_instr), 32'h0000C155);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 1);
        checkOutput("seq_pc1", 32'(if_pc), 1);
        checkOutput("seq_instr1", 32'(if_instr), 32'h0000C154);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 4);
        checkOutput("pre_stall_pc", 32'(if_pc), 5);
        checkOutput("pre_stall_addr", 32'(imem_addr), 7);

        applyStimulus(1'b0, 11'h000, 1'b0, 1'b0, 4);
        checkOutput("stall_valid", 32'(if_valid), 1);
        checkOutput("stall_pc", 32'(if_pc), 5);
        checkOutput("stall_addr", 32'(imem_addr), 7);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 1);
        checkOutput("skid_drain_pc", 32'(if_pc), 6);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 1);
        checkOutput("bubble_valid", 32'(if_valid), 0);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 1);
        checkOutput("resume_pc", 32'(if_pc), 7);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 2);
        checkOutput("pre_branch_pc", 32'(if_pc), 9);
        checkOutput("pre_branch_addr", 32'(imem_addr), 11);

        applyStimulus(1'b1, 11'h040, 1'b0, 1'b1, 1);
        checkOutput("branch_flush_valid", 32'(if_valid), 0);
        checkOutput("branch_target_addr", 32'(imem_addr), 32'h040);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 2);
        checkOutput("branch_target_valid", 32'(if_valid), 1);
        checkOutput("branch_target_pc", 32'(if_pc), 32'h040);

        applyStimulus(1'b0, 11'h000, 1'b0, 1'b0, 2);
        checkOutput("skid_full_pc", 32'(if_pc), 32'h040);
        checkOutput("skid_full_addr", 32'(imem_addr), 32'h042);
        applyStimulus(1'b1, 11'h7FE, 1'b0, 1'b0, 1);
        checkOutput("stall_branch_valid", 32'(if_valid), 0);
        checkOutput("stall_branch_addr", 32'(imem_addr), 32'h7FE);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 2);
        checkOutput("wrap_pc_7fe", 32'(if_pc), 32'h7FE);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 1);
        checkOutput("wrap_pc_7ff", 32'(if_pc), 32'h7FF);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 1);
        checkOutput("wrap_pc_000", 32'(if_pc), 0);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 1);
        checkOutput("wrap_pc_001", 32'(if_pc), 1);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 2);
        checkOutput("pre_halt_pc", 32'(if_pc), 3);

        applyStimulus(1'b0, 11'h000, 1'b1, 1'b1, 1);
        checkOutput("halt_drain_pc", 32'(if_pc), 4);
        checkOutput("halt_pc_frozen", 32'(imem_addr), 5);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 1);
        checkOutput("halt_empty", 32'(if_valid), 0);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 4);
        checkOutput("halt_sticky_rd_en", 32'(imem_rd_en), 0);
        checkOutput("halt_sticky_addr", 32'(imem_addr), 5);

        reset = 1'b0;
        #1;
        checkOutput("halt_rst_addr", 32'(imem_addr), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 3);
        checkOutput("restart_pc0", 32'(if_pc), 0);
        checkOutput("restart_valid", 32'(if_valid), 1);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 3);
        checkOutput("restart_pc3", 32'(if_pc), 3);
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b0, 2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(if_valid), 0);
        checkOutput("midrst_pc", 32'(if_pc), 0);
        checkOutput("midrst_instr", 32'(if_instr), 0);
        checkOutput("midrst_addr", 32'(imem_addr), 0);
        checkOutput("midrst_rd_en", 32'(imem_rd_en), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 11'h000, 1'b0, 1'b1, 5);
        checkOutput("after_midrst_pc", 32'(if_pc), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
